// File: rtl/des_pkg.sv
// -----------------------------------------------------------------------------
// des_pkg
//   Shared definitions for the DES block-mode sequencer.
//   - des_state_t : sequencer FSM states
//   - DES_BLK_W   : DES block / key width in bits
//   - DES_ENC/DEC : core mode encodings
// -----------------------------------------------------------------------------
package des_pkg;

    localparam int   DES_BLK_W = 64;
    localparam logic DES_ENC   = 1'b0;
    localparam logic DES_DEC   = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        OUT   = 2'd3
    } des_state_t;

endpackage

// File: rtl/des_cbc_ctrl.sv
// -----------------------------------------------------------------------------
// des_cbc_ctrl
//   Block-mode sequencer around a DES core. Takes 64-bit blocks from a
//   valid/ready input stream, applies ECB or CBC chaining, starts the core,
//   waits (bounded by TIMEOUT) for its result and hands the processed block
//   out on a valid/ready output stream. One block in flight at a time.
//
//   Ports
//     clk, rst_n           : clock, async active-low reset
//     cfg_load             : latch cfg_mode/cfg_cbc/cfg_iv/cfg_key (IDLE only)
//     cfg_mode, cfg_cbc    : 0 enc / 1 dec, 0 ECB / 1 CBC
//     cfg_iv, cfg_key      : initial chaining value, DES key
//     s_valid/s_ready/s_data : input block stream
//     m_valid/m_ready/m_data : output block stream
//     core_start/core_mode/core_key/core_din : drive the DES core
//     core_dout/core_dat_valid               : DES core result
//     busy                 : FSM not in IDLE
//     err_timeout          : sticky core timeout flag, cleared by cfg_load
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | accept config or a new block
//   START | one-cycle core_start pulse, wait counter cleared
//   WAIT  | wait for core_dat_valid, abandon block after TIMEOUT cycles
//   OUT   | hold result on m_* until the consumer takes it
// -----------------------------------------------------------------------------
module des_cbc_ctrl
    import des_pkg::*;
#(
    parameter  int TIMEOUT = 64,
    localparam int CNT_W   = $clog2(TIMEOUT + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cfg_load,
    input  logic                 cfg_mode,
    input  logic                 cfg_cbc,
    input  logic [DES_BLK_W-1:0] cfg_iv,
    input  logic [DES_BLK_W-1:0] cfg_key,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [DES_BLK_W-1:0] s_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [DES_BLK_W-1:0] m_data,
    output logic                 core_start,
    output logic                 core_mode,
    output logic [DES_BLK_W-1:0] core_key,
    output logic [DES_BLK_W-1:0] core_din,
    input  logic [DES_BLK_W-1:0] core_dout,
    input  logic                 core_dat_valid,
    output logic                 busy,
    output logic                 err_timeout
);

    des_state_t           state;
    des_state_t           state_nxt;
    logic                 cbc;
    logic [DES_BLK_W-1:0] chain;
    logic [DES_BLK_W-1:0] blk;
    logic [CNT_W-1:0]     cnt;

    logic take_cfg;
    logic take_blk;
    logic cnt_last;
    logic timeout;
    logic xor_in;
    logic xor_out;

    assign take_cfg = (state == IDLE) && cfg_load;
    assign take_blk = (state == IDLE) && !cfg_load && s_valid;
    assign cnt_last = (cnt == CNT_W'(TIMEOUT - 1));
    // A result arriving on the last allowed cycle is still taken.
    assign timeout  = (state == WAIT) && !core_dat_valid && cnt_last;
    assign xor_in   = cbc && (core_mode == DES_ENC);
    assign xor_out  = cbc && (core_mode == DES_DEC);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (take_blk) state_nxt = START;
            START:   state_nxt = WAIT;
            WAIT: begin
                if (core_dat_valid) begin
                    state_nxt = OUT;
                end else if (cnt_last) begin
                    state_nxt = IDLE;
                end
            end
            OUT:     if (m_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from state. s_ready is also held low while rst_n is
    // asserted so the input stream sees no acceptance during reset.
    always_comb begin
        s_ready    = 1'b0;
        core_start = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                s_ready = rst_n && !cfg_load;
                busy    = 1'b0;
            end
            START:   core_start = 1'b1;
            default: ;
        endcase
    end

    // Datapath: configuration, chaining value, core interface, result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cbc         <= 1'b0;
            core_mode   <= DES_ENC;
            core_key    <= '0;
            chain       <= '0;
            blk         <= '0;
            core_din    <= '0;
            m_data      <= '0;
            m_valid     <= 1'b0;
            err_timeout <= 1'b0;
            cnt         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (take_cfg) begin
                        cbc         <= cfg_cbc;
                        core_mode   <= cfg_mode;
                        core_key    <= cfg_key;
                        chain       <= cfg_iv;
                        err_timeout <= 1'b0;
                    end else if (take_blk) begin
                        blk      <= s_data;
                        core_din <= xor_in ? (s_data ^ chain) : s_data;
                    end
                end
                START: cnt <= '0;
                WAIT: begin
                    cnt <= cnt + CNT_W'(1);
                    if (core_dat_valid) begin
                        m_data  <= xor_out ? (core_dout ^ chain) : core_dout;
                        m_valid <= 1'b1;
                        if (cbc) begin
                            // Next block chains on the ciphertext side.
                            chain <= (core_mode == DES_ENC) ? core_dout : blk;
                        end
                    end else if (timeout) begin
                        err_timeout <= 1'b1;
                    end
                end
                OUT: if (m_ready) m_valid <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_des_cbc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_des_cbc_ctrl
//   Self-checking bench for des_cbc_ctrl. A behavioural DES core with
//   programmable latency answers core_start; a block-level reference model
//   (chain value, mode, key) predicts core_din and m_data for every block.
// -----------------------------------------------------------------------------
module tb_des_cbc_ctrl;

    localparam int TO = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_load = 1'b0;
    logic        cfg_mode = 1'b0;
    logic        cfg_cbc = 1'b0;
    logic [63:0] cfg_iv = '0;
    logic [63:0] cfg_key = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [63:0] s_data = '0;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [63:0] m_data;
    logic        core_start;
    logic        core_mode;
    logic [63:0] core_key;
    logic [63:0] core_din;
    logic [63:0] core_dout;
    logic        core_dat_valid;
    logic        busy;
    logic        err_timeout;

    des_cbc_ctrl #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_load(cfg_load), .cfg_mode(cfg_mode), .cfg_cbc(cfg_cbc),
        .cfg_iv(cfg_iv), .cfg_key(cfg_key),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .core_start(core_start), .core_mode(core_mode), .core_key(core_key),
        .core_din(core_din), .core_dout(core_dout),
        .core_dat_valid(core_dat_valid),
        .busy(busy), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    // ---------------- DES tables ----------------
    int ip_t[64] = '{58,50,42,34,26,18,10,2,60,52,44,36,28,20,12,4,
                     62,54,46,38,30,22,14,6,64,56,48,40,32,24,16,8,
                     57,49,41,33,25,17,9,1,59,51,43,35,27,19,11,3,
                     61,53,45,37,29,21,13,5,63,55,47,39,31,23,15,7};
    int fp_t[64] = '{40,8,48,16,56,24,64,32,39,7,47,15,55,23,63,31,
                     38,6,46,14,54,22,62,30,37,5,45,13,53,21,61,29,
                     36,4,44,12,52,20,60,28,35,3,43,11,51,19,59,27,
                     34,2,42,10,50,18,58,26,33,1,41,9,49,17,57,25};
    int e_t[48]  = '{32,1,2,3,4,5,4,5,6,7,8,9,8,9,10,11,12,13,12,13,14,15,16,17,
                     16,17,18,19,20,21,20,21,22,23,24,25,24,25,26,27,28,29,28,29,30,31,32,1};
    int p_t[32]  = '{16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,
                     2,8,24,14,32,27,3,9,19,13,30,6,22,11,4,25};
    int pc1_t[56] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,10,2,59,51,43,35,27,19,11,3,60,52,44,36,
                      63,55,47,39,31,23,15,7,62,54,46,38,30,22,14,6,61,53,45,37,29,21,13,5,28,20,12,4};
    int pc2_t[48] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,26,8,16,7,27,20,13,2,
                      41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
    int sh_t[16]  = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
    int sbox[8][64] = '{
        '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
          4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
        '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
          0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
        '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
          13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
        '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
          10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
        '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
          4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
        '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
          9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
        '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
          1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
        '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
          7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}};

    function automatic logic [63:0] des_ref(input logic [63:0] din, input logic [63:0] key,
                                            input logic dec);
        logic [55:0] cd;
        logic [27:0] c, d;
        logic [47:0] ks[16];
        logic [63:0] ipv, pre, res;
        logic [31:0] l, r, t, f, sb;
        logic [47:0] e, x;
        logic [5:0]  six;
        int          row, col, sv;
        for (int i = 0; i < 56; i++) cd[55-i] = key[64-pc1_t[i]];
        c = cd[55:28];
        d = cd[27:0];
        for (int k = 0; k < 16; k++) begin
            for (int s = 0; s < sh_t[k]; s++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
            cd = {c, d};
            for (int i = 0; i < 48; i++) ks[k][47-i] = cd[56-pc2_t[i]];
        end
        for (int i = 0; i < 64; i++) ipv[63-i] = din[64-ip_t[i]];
        l = ipv[63:32];
        r = ipv[31:0];
        for (int k = 0; k < 16; k++) begin
            for (int i = 0; i < 48; i++) e[47-i] = r[32-e_t[i]];
            x = e ^ ks[dec ? 15 - k : k];
            for (int s = 0; s < 8; s++) begin
                six = x[47-6*s -: 6];
                row = int'({six[5], six[0]});
                col = int'(six[4:1]);
                sv  = sbox[s][row*16 + col];
                sb[31-4*s -: 4] = sv[3:0];
            end
            for (int i = 0; i < 32; i++) f[31-i] = sb[32-p_t[i]];
            t = r;
            r = l ^ f;
            l = t;
        end
        pre = {r, l};
        for (int i = 0; i < 64; i++) res[63-i] = pre[64-fp_t[i]];
        return res;
    endfunction

    // ---------------- behavioural DES core ----------------
    int          stub_lat = 1;   // 0 = never answers
    int          pend = 0;
    logic        stub_v = 1'b0;
    logic [63:0] stub_dout = '0;
    logic [63:0] cur_dout = '0;
    logic        inj_v = 1'b0;
    logic [63:0] inj_dout = '0;
    logic        prev_start = 1'b0;
    int          starts = 0;
    int          double_start = 0;

    assign core_dat_valid = stub_v | inj_v;
    assign core_dout      = inj_v ? inj_dout : stub_dout;

    always @(negedge clk) begin
        stub_v = 1'b0;
        if (core_start) begin
            starts++;
            if (prev_start) double_start++;
            pend     = stub_lat;
            cur_dout = des_ref(core_din, core_key, core_mode);
        end else if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                stub_v    = 1'b1;
                stub_dout = cur_dout;
            end
        end
        prev_start = core_start;
    end

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model state ----------------
    logic        r_mode = 1'b0;
    logic        r_cbc = 1'b0;
    logic [63:0] r_key = '0;
    logic [63:0] r_chain = '0;
    int          exp_starts = 0;

    task automatic model_reset();
        r_mode = 1'b0; r_cbc = 1'b0; r_key = '0; r_chain = '0;
    endtask

    task automatic do_cfg(input logic mode, input logic cbc, input logic [63:0] iv,
                          input logic [63:0] key);
        cfg_load = 1'b1; cfg_mode = mode; cfg_cbc = cbc; cfg_iv = iv; cfg_key = key;
        @(negedge clk);
        cfg_load = 1'b0;
        cfg_mode = 1'($urandom); cfg_cbc = 1'($urandom);
        cfg_iv = {$urandom, $urandom}; cfg_key = {$urandom, $urandom};
        r_mode = mode; r_cbc = cbc; r_key = key; r_chain = iv;
    endtask

    // Presents one block and returns at the negedge of the core_start cycle.
    task automatic send_only(input logic [63:0] p);
        int n = 0;
        while (!s_ready && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) chk("sready_wait", 64'(n), 64'(0));
        s_valid = 1'b1; s_data = p;
        @(negedge clk);
        s_valid = 1'b0; s_data = {$urandom, $urandom};
        exp_starts++;
        chk("core_start", 64'(core_start), 64'(1));
    endtask

    task automatic run_block(input logic [63:0] p, input int lat, input int hold,
                             output logic [63:0] got_din, output logic [63:0] got_out);
        int          n;
        int          st0;
        logic [63:0] exp_din, exp_r, exp_out, held;
        stub_lat = lat;
        send_only(p);
        exp_din = (r_cbc && !r_mode) ? (p ^ r_chain) : p;
        got_din = core_din;
        chk("core_din", core_din, exp_din);
        chk("core_mode", 64'(core_mode), 64'(r_mode));
        chk("core_key", core_key, r_key);
        n = 0;
        while (!m_valid && n < 300) begin @(negedge clk); n++; end
        chk("out_latency", 64'(n), 64'(lat + 1));
        exp_r   = des_ref(exp_din, r_key, r_mode);
        exp_out = (r_cbc && r_mode) ? (exp_r ^ r_chain) : exp_r;
        got_out = m_data;
        chk("m_data", m_data, exp_out);
        held = m_data;
        st0  = starts;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("bp_m_valid", 64'(m_valid), 64'(1));
            chk("bp_m_data", m_data, held);
            chk("bp_s_ready", 64'(s_ready), 64'(0));
        end
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        chk("post_m_valid", 64'(m_valid), 64'(0));
        chk("post_busy", 64'(busy), 64'(0));
        chk("post_s_ready", 64'(s_ready), 64'(1));
        chk("bp_no_start", 64'(starts), 64'(st0));
        if (r_cbc) r_chain = r_mode ? p : exp_r;
    endtask

    task automatic expect_timeout(input logic [63:0] p, input int lat);
        int   n = 0;
        logic any_mv = 1'b0;
        stub_lat = lat;
        send_only(p);
        while (!err_timeout && n < 300) begin
            @(negedge clk); n++;
            any_mv |= m_valid;
        end
        chk("timeout_cycles", 64'(n), 64'(TO + 1));
        chk("timeout_busy", 64'(busy), 64'(0));
        for (int i = 0; i < 5; i++) begin @(negedge clk); any_mv |= m_valid; end
        chk("timeout_no_m_valid", 64'(any_mv), 64'(0));
        chk("timeout_sticky", 64'(err_timeout), 64'(1));
    endtask

    localparam logic [63:0] KAT_KEY = 64'h133457799BBCDFF1;
    localparam logic [63:0] KAT_P   = 64'h0123456789ABCDEF;
    localparam logic [63:0] KAT_C   = 64'h85E813540F0AB405;

    initial begin
        logic [63:0] gd, go, c2;
        int          st0;
        logic        any_mv;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_s_ready", 64'(s_ready), 64'(0));
        chk("rst_m_valid", 64'(m_valid), 64'(0));
        chk("rst_core_start", 64'(core_start), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_err", 64'(err_timeout), 64'(0));
        chk("rst_m_data", m_data, 64'h0);
        chk("rst_core_din", core_din, 64'h0);
        chk("rst_core_key", core_key, 64'h0);
        chk("rst_core_mode", 64'(core_mode), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_s_ready", 64'(s_ready), 64'(1));

        // CBC encrypt known answer
        do_cfg(1'b0, 1'b1, 64'h0, KAT_KEY);
        run_block(KAT_P, 3, 0, gd, go);
        chk("kat_cbc_enc_din1", gd, KAT_P);
        chk("kat_cbc_enc_ct1", go, KAT_C);
        run_block(KAT_P, 5, 0, gd, go);
        chk("kat_cbc_enc_din2", gd, 64'h84CB563386A179EA);

        // CBC decrypt known answer
        do_cfg(1'b1, 1'b1, 64'h0, KAT_KEY);
        run_block(KAT_C, 2, 0, gd, go);
        chk("kat_cbc_dec_din", gd, KAT_C);
        chk("kat_cbc_dec_pt", go, KAT_P);
        c2 = {$urandom, $urandom};
        run_block(c2, 4, 0, gd, go);
        chk("kat_cbc_dec_chain", go, des_ref(c2, KAT_KEY, 1'b1) ^ KAT_C);

        // ECB encrypt ignores IV
        do_cfg(1'b0, 1'b0, 64'hFFFFFFFFFFFFFFFF, KAT_KEY);
        for (int i = 0; i < 2; i++) begin
            run_block(KAT_P, 1 + i, 0, gd, go);
            chk("kat_ecb_din", gd, KAT_P);
            chk("kat_ecb_ct", go, KAT_C);
        end

        // Backpressure for 10 cycles
        run_block({$urandom, $urandom}, 6, 10, gd, go);

        // Randomized configurations and blocks
        for (int cfgn = 0; cfgn < 6; cfgn++) begin
            do_cfg(1'($urandom), 1'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
            for (int b = 0; b < 3; b++)
                run_block({$urandom, $urandom}, int'($urandom_range(1, 12)),
                          int'($urandom_range(0, 3)), gd, go);
        end

        // Timeout: core never answers; chain must survive the dropped block
        do_cfg(1'b0, 1'b1, {$urandom, $urandom}, {$urandom, $urandom});
        run_block({$urandom, $urandom}, 4, 0, gd, go);
        expect_timeout({$urandom, $urandom}, 0);
        run_block({$urandom, $urandom}, 5, 1, gd, go);
        chk("err_still_set", 64'(err_timeout), 64'(1));

        // cfg_load together with s_valid: config taken, block refused
        st0 = starts;
        cfg_load = 1'b1; cfg_mode = 1'b1; cfg_cbc = 1'b1;
        cfg_iv = {$urandom, $urandom}; cfg_key = {$urandom, $urandom};
        s_valid = 1'b1; s_data = {$urandom, $urandom};
        #1;
        chk("cfg_s_ready", 64'(s_ready), 64'(0));
        r_mode = cfg_mode; r_cbc = cfg_cbc; r_key = cfg_key; r_chain = cfg_iv;
        @(negedge clk);
        cfg_load = 1'b0; s_valid = 1'b0;
        chk("cfg_clr_err", 64'(err_timeout), 64'(0));
        chk("cfg_not_busy", 64'(busy), 64'(0));
        repeat (3) @(negedge clk);
        chk("cfg_no_start", 64'(starts), 64'(st0));
        run_block({$urandom, $urandom}, 2, 0, gd, go);

        // Latency boundary: answer on the last allowed cycle is taken
        run_block({$urandom, $urandom}, TO, 0, gd, go);
        chk("boundary_no_err", 64'(err_timeout), 64'(0));
        expect_timeout({$urandom, $urandom}, TO + 1);

        // Reset in WAIT, then stray dat_valid pulses in IDLE
        do_cfg(1'b0, 1'b1, {$urandom, $urandom}, {$urandom, $urandom});
        stub_lat = 30;
        send_only({$urandom, $urandom});
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("mid_rst_busy", 64'(busy), 64'(0));
        chk("mid_rst_core_start", 64'(core_start), 64'(0));
        chk("mid_rst_m_valid", 64'(m_valid), 64'(0));
        chk("mid_rst_s_ready", 64'(s_ready), 64'(0));
        chk("mid_rst_core_din", core_din, 64'h0);
        chk("mid_rst_core_key", core_key, 64'h0);
        chk("mid_rst_err", 64'(err_timeout), 64'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        st0 = starts;
        any_mv = 1'b0;
        for (int i = 0; i < 40; i++) begin
            inj_v = (i % 7 == 3);
            inj_dout = {$urandom, $urandom};
            @(negedge clk);
            any_mv |= m_valid;
        end
        inj_v = 1'b0;
        chk("stray_no_m_valid", 64'(any_mv), 64'(0));
        chk("stray_no_start", 64'(starts), 64'(st0));
        chk("stray_busy", 64'(busy), 64'(0));
        run_block({$urandom, $urandom}, 3, 0, gd, go);

        chk("start_count", 64'(starts), 64'(exp_starts));
        chk("double_start", 64'(double_start), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/des_cbc_ctrl.md
Name: des_cbc_ctrl

Overview:
Block-mode sequencer that drives the DES_top core's start/din/mode/key_din inputs and consumes its dout/dat_valid result.
- Accepts 64-bit blocks from a host stream (valid/ready).
- Applies ECB or CBC chaining around the core.
- Returns processed blocks on an output stream (valid/ready).
- Sits between the bus-side FIFO/CSR logic and the DES core; it is the initiator of the core's start/dat_valid protocol.

Parameters:
TIMEOUT, 64, max cycles from core_start to core_dat_valid before the block is abandoned (must be ≥ 2).
CNT_W, $clog2(TIMEOUT+1), width of the wait counter (derived; not overridden).

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
cfg_load  in  1  pulse: latch cfg_mode/cfg_cbc/cfg_iv/cfg_key, reset chain value
cfg_mode  in  1  0 encrypt, 1 decrypt
cfg_cbc  in  1  0 ECB, 1 CBC
cfg_iv  in  64  initial chaining value
cfg_key  in  64  DES key
s_valid  in  1  input block valid
s_ready  out  1  input block accepted when s_valid&s_ready
s_data  in  64  input block
m_valid  out  1  output block valid
m_ready  in  1  output consumer ready
m_data  out  64  output block
core_start  out  1  single-cycle start pulse to DES core
core_mode  out  1  registered mode to core
core_key  out  64  registered key to core
core_din  out  64  block to core, stable from core_start until core_dat_valid
core_dout  in  64  core result
core_dat_valid  in  1  core result valid (one-cycle pulse)
busy  out  1  FSM not in IDLE
err_timeout  out  1  sticky; set on timeout, cleared by cfg_load

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE; s_ready, m_valid, core_start, busy, err_timeout = 0; m_data, core_din, core_key, chain, blk = 0; core_mode = 0; mode/cbc regs = 0.
- States: IDLE, START, WAIT, OUT.
- IDLE:
  - s_ready = ~cfg_load (combinational off registered state).
  - If cfg_load: latch config; chain<=cfg_iv; clear err_timeout; stay in IDLE. A simultaneous s_valid is not accepted.
  - Else if s_valid: blk<=s_data. core_din<= s_data^chain when (cbc & encrypt), else s_data. Go to START.
- START: core_start=1 for exactly this cycle; wait counter<=0; go to WAIT.
- WAIT:
  - Counter increments every cycle.
  - On core_dat_valid, m_data is:
    - encrypt: core_dout;
    - decrypt with CBC: core_dout^chain;
    - decrypt with ECB: core_dout.
  - Chain update when CBC: encrypt: chain<=core_dout; decrypt: chain<=blk. Then m_valid<=1 and go to OUT.
  - If counter reaches TIMEOUT with no dat_valid: err_timeout<=1, chain unchanged, block dropped, go to IDLE.
  - dat_valid on the same cycle as timeout wins (result taken, no error).
- OUT: m_valid held with m_data stable until m_ready; on m_valid&m_ready → m_valid<=0, go to IDLE.
- Latency: s handshake at cycle N → core_start at N+1 → core_dat_valid at N+1+L → m_valid at N+2+L. Throughput is one block per L+3 cycles minimum (no overlap).
- core_dat_valid outside WAIT is ignored.
- cfg_load outside IDLE is ignored (host must check busy=0).
- core_mode/core_key change only on cfg_load in IDLE and are stable during any operation.
- cfg_cbc=0: chain is never used or updated.
- Mid-operation reset: everything returns to reset values immediately, with no spurious core_start or m_valid after release.

Decomposition:
- Shared package des_pkg: state enum (IDLE, START, WAIT, OUT), block width constant DES_BLK_W=64, mode encodings DES_ENC=0/DES_DEC=1.
- No sub-module; the chaining XOR and FSM stay in one module.
- Bench uses the real DES_top as the core, plus a behavioural stub core with programmable latency for timeout tests.

Test Plan:
- CBC encrypt, key 133457799BBCDFF1, IV 0, P=0123456789ABCDEF → core_din=0123456789ABCDEF, m_data=85E813540F0AB405. Second P=0123456789ABCDEF → core_din=84CB563386A179EA.
- CBC decrypt, same key, IV 0, C=85E813540F0AB405 → m_data=0123456789ABCDEF, chain=85E813540F0AB405. A second C then XORs its core_dout with 85E813540F0AB405.
- ECB encrypt, IV=FFFFFFFFFFFFFFFF, P=0123456789ABCDEF twice → core_din=0123456789ABCDEF both times, m_data=85E813540F0AB405 both times.
- Backpressure: m_ready=0 for 10 cycles in OUT → m_valid and m_data stable, s_ready=0, no core_start. m_ready=1 → IDLE next cycle, s_ready=1.
- Stub core never asserts dat_valid, TIMEOUT=64 → err_timeout=1 exactly 64 cycles after WAIT entry, m_valid stays 0. cfg_load then clears err_timeout. cfg_load together with s_valid in IDLE → block not accepted.
- Assert rst_n=0 during WAIT, and core_dat_valid pulses while in IDLE → outputs at reset values, no m_valid, no chain change.
